reg_file_rename: RTL and testbench

Architectural register file with per-register ROB rename tags for the out-of-order RISC-V core. Sits directly downstream of the reorder buffer: it consumes the ROB commit stream (destination, value, ROB id) and retires values into 32 architectural registers. It also serves the dispatcher with combinational source-operand lookups (value or producing ROB tag) and accepts destination renames at dispatch. A flush input discards all in-flight renames on misprediction.

---
 rtl/reg_file_rename.sv | 125 ++++++++++++
 tb/tb_reg_file_rename.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register ROB rename
// tags. Retires ROB commits, records dispatch renames, and serves two
// combinational source lookups (value when idle, producing tag when busy).
//
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   rdy_in                  global enable (low freezes state)
//   flush_in                clears every busy bit and tag
//   rename_*_dp_in          dispatcher destination rename
//   rs1/rs2_dp_in           source indices; *_busy/_val/_rob_dp_out results
//   rdy_commit_rob_in,
//   dest/value/rob_id_rob_in  ROB commit stream
//
// Option: define RF_COMMIT_FWD_EN to bypass a same-cycle matching commit
// onto the source read ports.
module reg_file_rename #(
    parameter int REG_NUM    = 32,
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  rename_en_dp_in,
    input  logic [REG_WIDTH-1:0]  rename_rd_dp_in,
    input  logic [ROB_WIDTH-1:0]  rename_rob_dp_in,
    input  logic [REG_WIDTH-1:0]  rs1_dp_in,
    input  logic [REG_WIDTH-1:0]  rs2_dp_in,
    output logic                  rs1_busy_dp_out,
    output logic                  rs2_busy_dp_out,
    output logic [DATA_WIDTH-1:0] rs1_val_dp_out,
    output logic [DATA_WIDTH-1:0] rs2_val_dp_out,
    output logic [ROB_WIDTH-1:0]  rs1_rob_dp_out,
    output logic [ROB_WIDTH-1:0]  rs2_rob_dp_out,
    input  logic                  rdy_commit_rob_in,
    input  logic [REG_WIDTH-1:0]  dest_rob_in,
    input  logic [DATA_WIDTH-1:0] value_rob_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_rob_in
);

    localparam int LW = 1 + ROB_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] value_q [REG_NUM];
    logic [DATA_WIDTH-1:0] value_d [REG_NUM];
    logic [ROB_WIDTH-1:0]  tag_q   [REG_NUM];
    logic [ROB_WIDTH-1:0]  tag_d   [REG_NUM];
    logic [REG_NUM-1:0]    busy_q;
    logic [REG_NUM-1:0]    busy_d;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = rdy_in && rdy_commit_rob_in
                       && (dest_rob_in != '0);
    assign rename_ok = rdy_in && rename_en_dp_in
                       && (rename_rd_dp_in != '0);

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        // Commit value always lands; busy clears only if the committing
        // entry is still the youngest producer of this register.
        if (commit_ok) begin
            value_d[dest_rob_in] = value_rob_in;
            if (busy_q[dest_rob_in]
                && tag_q[dest_rob_in] == rob_id_rob_in) begin
                busy_d[dest_rob_in] = 1'b0;
            end
        end
        if (rdy_in && flush_in) begin
            busy_d = '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = '0;
            end
        end else if (rename_ok) begin
            busy_d[rename_rd_dp_in] = 1'b1;
            tag_d[rename_rd_dp_in]  = rename_rob_dp_in;
        end
        value_d[0] = '0;
        tag_d[0]   = '0;
        busy_d[0]  = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // Packed result: {busy, rob, value}
    function automatic logic [LW-1:0] lookup(
        input logic [REG_WIDTH-1:0] rs
    );
        logic [LW-1:0] r;
        r = {busy_q[rs], tag_q[rs], value_q[rs]};
`ifdef RF_COMMIT_FWD_EN
        if (busy_q[rs] && commit_ok && !flush_in
            && dest_rob_in == rs
            && rob_id_rob_in == tag_q[rs]) begin
            r = {1'b0, tag_q[rs], value_rob_in};
        end
`endif
        if (rs == '0) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        {rs1_busy_dp_out, rs1_rob_dp_out, rs1_val_dp_out} = lookup(rs1_dp_in);
        {rs2_busy_dp_out, rs2_rob_dp_out, rs2_val_dp_out} = lookup(rs2_dp_in);
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: vector table plus hand sequences, with expected
// read results queued as a scoreboard and popped at each check point.
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        ren;
    logic [4:0]  rd;
    logic [3:0]  rtag;
    logic [4:0]  rs1, rs2;
    logic        b1, b2;
    logic [31:0] v1, v2;
    logic [3:0]  r1, r2;
    logic        cen;
    logic [4:0]  cd;
    logic [31:0] cv;
    logic [3:0]  cid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .rdy_in            (rdy),
        .flush_in          (flush),
        .rename_en_dp_in   (ren),
        .rename_rd_dp_in   (rd),
        .rename_rob_dp_in  (rtag),
        .rs1_dp_in         (rs1),
        .rs2_dp_in         (rs2),
        .rs1_busy_dp_out   (b1),
        .rs2_busy_dp_out   (b2),
        .rs1_val_dp_out    (v1),
        .rs2_val_dp_out    (v2),
        .rs1_rob_dp_out    (r1),
        .rs2_rob_dp_out    (r2),
        .rdy_commit_rob_in (cen),
        .dest_rob_in       (cd),
        .value_rob_in      (cv),
        .rob_id_rob_in     (cid)
    );

    // ex holds the rob tag when busy, else the value
    typedef struct {
        logic        full;
        logic        b1;
        logic [31:0] x1;
        logic        b2;
        logic [31:0] x2;
    } exp_t;

    typedef struct {
        logic        rdy, ren;
        logic [4:0]  rd;
        logic [3:0]  rt;
        logic        cen;
        logic [4:0]  cd;
        logic [31:0] cv;
        logic [3:0]  cid;
        logic        fl;
        logic [4:0]  r1, r2;
        logic        e1b;
        logic [31:0] e1x;
        logic        e2b;
        logic [31:0] e2x;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    function automatic vec_t mk(
        input logic rdy_v, ren_v, input logic [4:0] rd_v,
        input logic [3:0] rt_v, input logic cen_v,
        input logic [4:0] cd_v, input logic [31:0] cv_v,
        input logic [3:0] cid_v, input logic fl_v,
        input logic [4:0] r1_v, r2_v,
        input logic e1b_v, input logic [31:0] e1x_v,
        input logic e2b_v, input logic [31:0] e2x_v
    );
        vec_t v;
        v.rdy = rdy_v; v.ren = ren_v; v.rd = rd_v; v.rt = rt_v;
        v.cen = cen_v; v.cd = cd_v; v.cv = cv_v; v.cid = cid_v;
        v.fl = fl_v; v.r1 = r1_v; v.r2 = r2_v;
        v.e1b = e1b_v; v.e1x = e1x_v; v.e2b = e2b_v; v.e2x = e2x_v;
        return v;
    endfunction

    function automatic exp_t ex(input logic full, input logic eb1,
                                input logic [31:0] ex1, input logic eb2,
                                input logic [31:0] ex2);
        exp_t e;
        e.full = full; e.b1 = eb1; e.x1 = ex1; e.b2 = eb2; e.x2 = ex2;
        return e;
    endfunction

    task automatic cmp1(input string nm, input logic full,
                        input logic eb, input logic [31:0] ex_v,
                        input logic ab, input logic [31:0] av,
                        input logic [3:0] ar);
        logic bad;
        checks++;
        bad = (ab !== eb);
        if (eb) bad = bad || (ar !== ex_v[3:0]);
        else    bad = bad || (av !== ex_v);
        if (full) bad = bad || (ar !== 4'd0) || (av !== 32'd0);
        if (bad) begin
            failures++;
            $display("FAIL %s: got busy=%0b val=%h rob=%0d, want busy=%0b %s=%h%s",
                     nm, ab, av, ar, eb, eb ? "rob" : "val", ex_v,
                     full ? " (all zero)" : "");
        end
    endtask

    task automatic check_pop(input string nm);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            cmp1({nm, ".rs1"}, e.full, e.b1, e.x1, b1, v1, r1);
            cmp1({nm, ".rs2"}, e.full, e.b2, e.x2, b2, v2, r2);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; ren = 1'b0; rd = '0; rtag = '0;
        cen = 1'b0; cd = '0; cv = '0; cid = '0;
    endtask

    initial begin
        idle();
        rs1 = 5'd3; rs2 = 5'd31;
        rst_n = 1'b0;

        //       rdy ren rd  rt cen cd  cv            cid fl r1  r2  e1b e1x           e2b e2x
        vecs[0]  = mk(1, 0, 0, 0, 1, 5, 32'hA5A50001, 0, 0, 5, 0, 0, 32'hA5A50001, 0, 0);
        vecs[1]  = mk(1, 1, 3, 7, 0, 0, 0, 0, 0, 3, 5, 1, 7, 0, 32'hA5A50001);
        vecs[2]  = mk(1, 0, 0, 0, 1, 3, 32'hDEADBEEF, 7, 0, 3, 3, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        vecs[3]  = mk(1, 1, 3, 2, 0, 0, 0, 0, 0, 3, 0, 1, 2, 0, 0);
        vecs[4]  = mk(1, 1, 3, 9, 0, 0, 0, 0, 0, 3, 0, 1, 9, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 1, 3, 32'h11, 2, 0, 3, 0, 1, 9, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 1, 3, 32'h22, 9, 0, 3, 0, 0, 32'h22, 0, 0);
        vecs[7]  = mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 1);
        vecs[8]  = mk(1, 1, 4, 6, 1, 4, 32'h55, 1, 0, 4, 0, 1, 6, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 1, 4, 32'h66, 6, 0, 4, 0, 0, 32'h66, 0, 0);
        vecs[10] = mk(1, 1, 8, 3, 0, 0, 0, 0, 0, 8, 0, 1, 3, 0, 0);
        vecs[11] = mk(1, 1, 9, 4, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 4);
        vecs[12] = mk(1, 1, 10, 5, 1, 11, 32'h77, 0, 1, 8, 10, 0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 11, 0, 0, 0, 32'h77);
        vecs[14] = mk(1, 1, 0, 5, 1, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 1, 31, 15, 0, 0, 0, 0, 0, 31, 0, 1, 15, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 1, 31, 32'hFFFFFFFF, 15, 0, 31, 0, 0, 32'hFFFFFFFF, 0, 0);
        vecs[17] = mk(0, 1, 13, 3, 1, 5, 32'h99, 0, 0, 13, 5, 0, 0, 0, 32'hA5A50001);

        #12;
        sb_q.push_back(ex(1, 0, 0, 0, 0));
        check_pop("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rdy = vecs[i].rdy; ren = vecs[i].ren;
            rd = vecs[i].rd; rtag = vecs[i].rt;
            cen = vecs[i].cen; cd = vecs[i].cd;
            cv = vecs[i].cv; cid = vecs[i].cid;
            flush = vecs[i].fl;
            rs1 = vecs[i].r1; rs2 = vecs[i].r2;
            sb_q.push_back(ex(0, vecs[i].e1b, vecs[i].e1x,
                              vecs[i].e2b, vecs[i].e2x));
            @(posedge clk);
            #1 idle();
            #1 check_pop($sformatf("vec%0d", i));
        end

        // Same-cycle commit to a busy source: bypass only when enabled
        @(negedge clk);
        ren = 1'b1; rd = 5'd7; rtag = 4'd5;
        rs1 = 5'd0; rs2 = 5'd7;
        @(posedge clk);
        #1 idle();
        cen = 1'b1; cd = 5'd7; cv = 32'h1234; cid = 4'd5;
        #1;
`ifdef RF_COMMIT_FWD_EN
        sb_q.push_back(ex(0, 0, 0, 0, 32'h1234));
`else
        sb_q.push_back(ex(0, 0, 0, 1, 5));
`endif
        check_pop("commit_bypass");
        flush = 1'b1;
        #1 sb_q.push_back(ex(0, 0, 0, 1, 5));
        check_pop("bypass_flush");
        flush = 1'b0;
        @(posedge clk);
        #1 idle();
        #1 sb_q.push_back(ex(0, 0, 0, 0, 32'h1234));
        check_pop("commit_x7");

        // Mid-cycle asynchronous reset wipes written registers
        rs1 = 5'd5; rs2 = 5'd7;
        #2 rst_n = 1'b0;
        #1 sb_q.push_back(ex(1, 0, 0, 0, 0));
        check_pop("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rs1 = 5'd31; rs2 = 5'd3;
        @(posedge clk);
        #1 sb_q.push_back(ex(1, 0, 0, 0, 0));
        check_pop("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
